tcm_arbiter: RTL and testbench

Two-master bus arbiter placed directly upstream of the TCM controller. It merges the instruction-fetch master (m0) and the data master (m1) onto the single TCM slave port using round-robin arbitration. A one-entry holding slot per master means a request that loses arbitration is never dropped. Slave responses and faults are routed back to the master that owns the transaction.

---
 rtl/tcm_arbiter_pkg.sv | 17 +
 rtl/bus_req_slot.sv | 42 ++++
 rtl/tcm_arbiter.sv | 107 ++++++++++
 tb/tb_tcm_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_arbiter_pkg.sv
// tcm_arbiter_pkg: bus geometry and request field bundle shared by the TCM arbiter
package tcm_arbiter_pkg;
    localparam int BUS_WIDTH      = 32;
    localparam int BUS_ACC_WIDTH  = 2;
    localparam int TCM_SIZE       = 65536;
    localparam int BUS_MASTER_CNT = 2;

    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

    typedef struct packed {
        logic                     w_rb;
        logic [BUS_ACC_WIDTH-1:0] acc;
        logic [BUS_WIDTH-1:0]     wdata;
    } bus_ctl_t;
endpackage

// File: rtl/bus_req_slot.sv
// bus_req_slot: one-entry holding register for a request that lost arbitration
module bus_req_slot
    import tcm_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  set_i,
    input  logic                  clr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  bus_ctl_t              ctl_i,
    output logic                  vld_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output bus_ctl_t              ctl_o
);
    logic                  vld_q, vld_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    bus_ctl_t              ctl_q, ctl_d;

    always_comb begin
        vld_d  = set_i ? 1'b1 : clr_i ? 1'b0 : vld_q;
        addr_d = set_i ? addr_i : addr_q;
        ctl_d  = set_i ? ctl_i : ctl_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            ctl_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            ctl_q  <= ctl_d;
        end
    end

    assign vld_o  = vld_q;
    assign addr_o = addr_q;
    assign ctl_o  = ctl_q;
endmodule

// File: rtl/tcm_arbiter.sv
// tcm_arbiter: round-robin merge of fetch (m0) and data (m1) masters onto the TCM slave port
module tcm_arbiter
    import tcm_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = $clog2(TCM_SIZE)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [ADDR_WIDTH-1:0]    m0_addr,
    input  logic                     m0_w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] m0_acc,
    input  logic [BUS_WIDTH-1:0]     m0_wdata,
    input  logic                     m0_req,
    output logic [BUS_WIDTH-1:0]     m0_rdata,
    output logic                     m0_resp,
    output logic                     m0_fault,
    input  logic [ADDR_WIDTH-1:0]    m1_addr,
    input  logic                     m1_w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] m1_acc,
    input  logic [BUS_WIDTH-1:0]     m1_wdata,
    input  logic                     m1_req,
    output logic [BUS_WIDTH-1:0]     m1_rdata,
    output logic                     m1_resp,
    output logic                     m1_fault,
    output logic [ADDR_WIDTH-1:0]    s_addr,
    output logic                     s_w_rb,
    output logic [BUS_ACC_WIDTH-1:0] s_acc,
    output logic [BUS_WIDTH-1:0]     s_wdata,
    output logic                     s_req,
    input  logic [BUS_WIDTH-1:0]     s_rdata,
    input  logic                     s_resp,
    input  logic                     s_fault
);
    logic [BUS_MASTER_CNT-1:0] req, pnd, inflight, live, cand, gnt;
    logic [ADDR_WIDTH-1:0]     addr_in [BUS_MASTER_CNT];
    logic [ADDR_WIDTH-1:0]     addr_pnd[BUS_MASTER_CNT];
    logic [ADDR_WIDTH-1:0]     addr_sel[BUS_MASTER_CNT];
    bus_ctl_t                  ctl_in  [BUS_MASTER_CNT];
    bus_ctl_t                  ctl_pnd [BUS_MASTER_CNT];
    bus_ctl_t                  ctl_sel [BUS_MASTER_CNT];
    logic                      busy_q, busy_d, owner_q, owner_d, lg_q, lg_d;
    logic                      gnt1, issue_ok, accept;

    assign req        = {m1_req, m0_req};
    assign addr_in[0] = m0_addr;
    assign addr_in[1] = m1_addr;
    assign ctl_in[0]  = {m0_w_rb, m0_acc, m0_wdata};
    assign ctl_in[1]  = {m1_w_rb, m1_acc, m1_wdata};

    for (genvar i = 0; i < BUS_MASTER_CNT; i++) begin : g_m
        // a master may re-request in the very cycle its response returns
        assign inflight[i] = busy_q & ~s_resp & (owner_q == 1'(i));
        assign live[i]     = req[i] & ~pnd[i] & ~inflight[i];
        assign cand[i]     = pnd[i] | live[i];
        assign addr_sel[i] = pnd[i] ? addr_pnd[i] : addr_in[i];
        assign ctl_sel[i]  = pnd[i] ? ctl_pnd[i] : ctl_in[i];

        bus_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot (
            .clk    (clk),
            .rstn   (rstn),
            .set_i  (live[i] & ~(s_req & gnt[i])),
            .clr_i  (s_req & gnt[i]),
            .addr_i (addr_in[i]),
            .ctl_i  (ctl_in[i]),
            .vld_o  (pnd[i]),
            .addr_o (addr_pnd[i]),
            .ctl_o  (ctl_pnd[i])
        );

        assert property (@(posedge clk) disable iff (!rstn) !(req[i] && (pnd[i] || inflight[i])))
            else $error("m%0d_req protocol violation dropped", i);
    end

    assign gnt1     = cand[1] & (~cand[0] | ~lg_q);
    assign gnt      = {gnt1, cand[0] & ~gnt1};
    assign issue_ok = ~busy_q | s_resp;
    assign s_req    = rstn & issue_ok & (|cand);
    assign accept   = s_req & ~s_fault;
    assign s_addr   = addr_sel[gnt1];
    assign {s_w_rb, s_acc, s_wdata} = ctl_sel[gnt1];

    always_comb begin
        busy_d  = accept | (busy_q & ~s_resp);
        owner_d = accept ? gnt1 : owner_q;
        lg_d    = s_req ? gnt1 : lg_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
            lg_q    <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
            lg_q    <= lg_d;
        end
    end

    // owner is the registered one, so a same-cycle new issue does not steal the response
    assign m0_resp  = rstn & s_resp & busy_q & ~owner_q;
    assign m1_resp  = rstn & s_resp & busy_q & owner_q;
    assign m0_fault = s_req & gnt[0] & s_fault;
    assign m1_fault = s_req & gnt[1] & s_fault;
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
endmodule

// File: tb/tb_tcm_arbiter.sv
// tb_tcm_arbiter: scoreboard bench with a simple TCM slave model and per-master reference memory
module tb_tcm_arbiter;
    import tcm_arbiter_pkg::*;

    typedef struct {
        logic        fault;
        logic        rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] ma[2];
    logic        mw[2];
    logic [1:0]  macc[2];
    logic [31:0] mwd[2];
    logic        mreq[2];
    logic [31:0] m0_rdata, m1_rdata, s_wdata, s_rdata, rd_q;
    logic        m0_resp, m0_fault, m1_resp, m1_fault;
    logic [15:0] s_addr;
    logic        s_w_rb, s_req, s_resp, s_fault, resp_q, inj, mem_clr;
    logic [1:0]  s_acc;
    logic [31:0] smem[128];
    logic [31:0] rmem[128];
    logic [127:0] smem_v;
    exp_t        expq[2][$];
    int          vecs = 0;
    int          errs = 0;
    int          cyc = 0;

    tcm_arbiter #(.ADDR_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn),
        .m0_addr(ma[0]), .m0_w_rb(mw[0]), .m0_acc(macc[0]), .m0_wdata(mwd[0]), .m0_req(mreq[0]),
        .m0_rdata(m0_rdata), .m0_resp(m0_resp), .m0_fault(m0_fault),
        .m1_addr(ma[1]), .m1_w_rb(mw[1]), .m1_acc(macc[1]), .m1_wdata(mwd[1]), .m1_req(mreq[1]),
        .m1_rdata(m1_rdata), .m1_resp(m1_resp), .m1_fault(m1_fault),
        .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata), .s_req(s_req),
        .s_rdata(s_rdata), .s_resp(s_resp), .s_fault(s_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic misal(input logic [15:0] a, input logic [1:0] acc);
        return (acc == 2'd3) || (acc == BUS_ACC_4B && a[1:0] != 2'd0) || (acc == BUS_ACC_2B && a[0]);
    endfunction

    function automatic logic [31:0] init_word(input logic [6:0] i);
        return (i == 7'd4) ? 32'hDEADBEEF : (32'h5A00_0000 | 32'(i));
    endfunction

    // TCM model: combinational reject of misaligned accesses, registered response
    assign s_fault = s_req & misal(s_addr, s_acc);
    assign s_resp  = resp_q | inj;
    assign s_rdata = rd_q;

    always @(posedge clk) begin
        resp_q <= s_req & ~s_fault;
        if (mem_clr) smem_v <= '0;
        else if (s_req & ~s_fault & s_w_rb) begin
            smem[s_addr[8:2]]   <= s_wdata;
            smem_v[s_addr[8:2]] <= 1'b1;
        end
        if (s_req & ~s_fault & ~s_w_rb)
            rd_q <= smem_v[s_addr[8:2]] ? smem[s_addr[8:2]] : init_word(s_addr[8:2]);
    end

    always @(negedge clk) begin
        if (!rstn) begin
            vecs++;
            if (s_req | m0_resp | m1_resp | m0_fault | m1_fault) begin
                errs++;
                $display("FAIL reset_quiet: got s_req=%0b resp=%0b%0b fault=%0b%0b, expected all 0",
                         s_req, m1_resp, m0_resp, m1_fault, m0_fault);
            end
        end
        for (int n = 0; n < 2; n++) begin
            logic r, f;
            logic [31:0] d;
            exp_t e;
            r = (n == 1) ? m1_resp : m0_resp;
            f = (n == 1) ? m1_fault : m0_fault;
            d = (n == 1) ? m1_rdata : m0_rdata;
            if (r || f) begin
                vecs++;
                if (expq[n].size() == 0) begin
                    errs++;
                    $display("FAIL m%0d_unexpected: got resp=%0b fault=%0b, expected no completion", n, r, f);
                end else begin
                    e = expq[n].pop_front();
                    if (f != e.fault || r == f || (e.rd && r && d != e.data)) begin
                        errs++;
                        $display("FAIL m%0d_completion: got resp=%0b fault=%0b rdata=%h, expected fault=%0b rdata=%h",
                                 n, r, f, d, e.fault, e.rd ? e.data : 32'h0);
                    end
                end
            end else if (expq[n].size() != 0 && cyc - expq[n][0].cyc > 20) begin
                vecs++;
                errs++;
                $display("FAIL m%0d_timeout: no completion within 20 cycles, expected one", n);
                void'(expq[n].pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mreq[0] = 1'b0;
        mreq[1] = 1'b0;
        inj     = 1'b0;
        mem_clr = 1'b0;
    endtask

    task automatic set_req(input int n, input logic [15:0] a, input logic w, input logic [1:0] acc,
                           input logic [31:0] d);
        exp_t e;
        e.fault = misal(a, acc);
        e.rd    = !w;
        e.cyc   = cyc;
        if (!e.fault && w) rmem[a[8:2]] = d;
        e.data = rmem[a[8:2]];
        expq[n].push_back(e);
        ma[n] = a; mw[n] = w; macc[n] = acc; mwd[n] = d; mreq[n] = 1'b1;
    endtask

    initial begin
        logic [15:0] a;
        rstn = 1'b0; inj = 1'b0; mem_clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ma[i] = '0; mw[i] = 1'b0; macc[i] = '0; mwd[i] = '0; mreq[i] = 1'b0;
        end
        for (int i = 0; i < 128; i++) rmem[i] = init_word(7'(i));
        tick();
        tick();
        rstn = 1'b1;
        // first tie after reset: m0 wins, m1 follows from its slot
        set_req(0, 16'h20, 1'b0, BUS_ACC_4B, 0);
        set_req(1, 16'h120, 1'b0, BUS_ACC_4B, 0);
        @(negedge clk); chk("tie0_sreq", 32'(s_req), 1); chk("tie0_addr", 32'(s_addr), 32'h20);
        tick();
        @(negedge clk); chk("tie0_slot_sreq", 32'(s_req), 1); chk("tie0_slot_addr", 32'(s_addr), 32'h120);
        chk("tie0_m0_resp", 32'(m0_resp), 1);
        tick();
        @(negedge clk); chk("tie0_m1_resp", 32'(m1_resp), 1); chk("tie0_idle", 32'(s_req), 0);
        tick();
        // lone m0 read passes straight through
        set_req(0, 16'h10, 1'b0, BUS_ACC_4B, 0);
        @(negedge clk); chk("solo_sreq", 32'(s_req), 1); chk("solo_addr", 32'(s_addr), 32'h10);
        tick();
        @(negedge clk); chk("solo_resp", 32'(m0_resp), 1); chk("solo_rdata", m0_rdata, 32'hDEADBEEF);
        chk("solo_m1_quiet", 32'(m1_resp), 0);
        tick();
        // tie with m0 last granted: m1 wins
        set_req(0, 16'h24, 1'b0, BUS_ACC_4B, 0);
        set_req(1, 16'h124, 1'b0, BUS_ACC_4B, 0);
        @(negedge clk); chk("tie1_addr", 32'(s_addr), 32'h124);
        tick();
        @(negedge clk); chk("tie1_slot_addr", 32'(s_addr), 32'h24); chk("tie1_m1_resp", 32'(m1_resp), 1);
        tick();
        @(negedge clk); chk("tie1_m0_resp", 32'(m0_resp), 1);
        tick();
        // misaligned write faults in the issue cycle and leaves the bus free
        set_req(1, 16'h2, 1'b1, BUS_ACC_4B, 32'h1234);
        @(negedge clk); chk("fault_m1", 32'(m1_fault), 1); chk("fault_no_resp", 32'(m1_resp), 0);
        tick();
        set_req(0, 16'h14, 1'b0, BUS_ACC_4B, 0);
        @(negedge clk); chk("fault_m1_after", 32'(m1_resp), 0); chk("fault_not_busy", 32'(s_req), 1);
        chk("fault_next_addr", 32'(s_addr), 32'h14);
        tick();
        tick();
        set_req(1, 16'h130, 1'b0, BUS_ACC_4B, 0);
        @(negedge clk); chk("m1_solo_addr", 32'(s_addr), 32'h130);
        tick();
        tick();
        // m1 loses the tie, then its held request faults when issued from the slot
        set_req(0, 16'h18, 1'b0, BUS_ACC_4B, 0);
        set_req(1, 16'h101, 1'b1, BUS_ACC_4B, 32'hCAFE);
        @(negedge clk); chk("slotf_win_addr", 32'(s_addr), 32'h18); chk("slotf_nofault", 32'(m1_fault), 0);
        tick();
        @(negedge clk); chk("slotf_addr", 32'(s_addr), 32'h101); chk("slotf_fault", 32'(m1_fault), 1);
        chk("slotf_m0_resp", 32'(m0_resp), 1);
        tick();
        set_req(1, 16'h134, 1'b0, BUS_ACC_4B, 0);
        @(negedge clk); chk("slotf_cleared_sreq", 32'(s_req), 1); chk("slotf_cleared_addr", 32'(s_addr), 32'h134);
        tick();
        tick();
        // alternating masters: one issue every cycle
        for (int i = 0; i < 8; i++) begin
            a = (i % 2 == 1) ? 16'(16'h140 + 4 * i) : 16'(16'h40 + 4 * i);
            set_req(i % 2, a, 1'(i >> 1), BUS_ACC_4B, 32'hA000 + 32'(i));
            @(negedge clk); chk("alt_sreq", 32'(s_req), 1); chk("alt_addr", 32'(s_addr), 32'(a));
            tick();
        end
        tick();
        tick();
        // reset while m0's read is in flight
        set_req(0, 16'h10, 1'b0, BUS_ACC_4B, 0);
        @(negedge clk); chk("rst_issue", 32'(s_req), 1);
        tick();
        rstn = 1'b0;
        @(negedge clk); chk("rst_no_resp", 32'(m0_resp), 0);
        expq[0].delete();
        tick();
        rstn = 1'b1;
        inj  = 1'b1;
        @(negedge clk); chk("rst_late_m0", 32'(m0_resp), 0); chk("rst_late_m1", 32'(m1_resp), 0);
        tick();
        set_req(0, 16'h1C, 1'b0, BUS_ACC_4B, 0);
        @(negedge clk); chk("post_rst_sreq", 32'(s_req), 1); chk("post_rst_addr", 32'(s_addr), 32'h1C);
        tick();
        @(negedge clk); chk("post_rst_resp", 32'(m0_resp), 1);
        tick();
        repeat (400) begin
            for (int n = 0; n < 2; n++) begin
                if (expq[n].size() == 0 && $urandom_range(3) != 0) begin
                    a = 16'(n * 256 + int'($urandom_range(255)));
                    if ($urandom_range(3) != 0) a[1:0] = 2'd0;
                    set_req(n, a, 1'($urandom_range(1)), 2'($urandom_range(2)), $urandom);
                end
            end
            tick();
        end
        repeat (10) tick();
        chk("drain_m0", 32'(expq[0].size()), 0);
        chk("drain_m1", 32'(expq[1].size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
